// File: rtl/qoi_decoder.sv
// qoi_decoder: turns a QOI chunk byte stream into a pixel stream.
// One byte in and at most one pixel out per cycle, through a registered output.
module qoi_decoder #(
    parameter int COMPONENTS = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    frame_start,
    input  logic [7:0]              istream,
    input  logic                    istream_valid,
    output logic                    istream_ready,
    output logic [8*COMPONENTS-1:0] pixel,
    output logic                    pixel_valid,
    input  logic                    pixel_ready
);
    typedef enum logic [3:0] {
        S_OP, S_RGB_R, S_RGB_G, S_RGB_B,
        S_RGBA_R, S_RGBA_G, S_RGBA_B, S_RGBA_A,
        S_LUMA2, S_RUN
    } state_t;

    state_t      state, state_nx;
    logic [31:0] prev, pix_q, px;
    logic [31:0] idx_mem [64];
    logic [63:0] idx_vld;
    logic [7:0]  tr, tg, tb, dg;
    logic [7:0]  tr_nx, tg_nx, tb_nx, dg_nx;
    logic [5:0]  run_cnt, cnt_nx, slot;
    logic [7:0]  pr, pg, pb, pa;
    logic [7:0]  df_r, df_g, df_b, lu_r, lu_g, lu_b;
    logic        vld_q, out_free, acc, issue;
    logic        op_rgb, op_rgba, op_idx, op_diff, op_luma, op_run;

    assign {pr, pg, pb, pa} = prev;
    assign out_free      = !vld_q | pixel_ready;
    assign istream_ready = rst_n & (state != S_RUN) & out_free;
    assign acc           = istream_valid & istream_ready;
    assign pixel_valid   = vld_q;

    assign op_rgb  = istream == 8'hFE;
    assign op_rgba = istream == 8'hFF;
    assign op_idx  = istream[7:6] == 2'b00;
    assign op_diff = istream[7:6] == 2'b01;
    assign op_luma = istream[7:6] == 2'b10;
    assign op_run  = istream[7:6] == 2'b11 & !op_rgb & !op_rgba;

    assign df_r = pr + {6'd0, istream[5:4]} - 8'd2;
    assign df_g = pg + {6'd0, istream[3:2]} - 8'd2;
    assign df_b = pb + {6'd0, istream[1:0]} - 8'd2;
    assign lu_g = pg + dg;
    assign lu_r = pr + dg + {4'd0, istream[7:4]} - 8'd8;
    assign lu_b = pb + dg + {4'd0, istream[3:0]} - 8'd8;

    // Hash taken mod 64 throughout, so only the low 6 bits of each channel matter
    assign slot = px[29:24] * 6'd3 + px[21:16] * 6'd5
                + px[13:8] * 6'd7 + px[5:0] * 6'd11;

    always_comb begin
        state_nx = state;
        tr_nx    = tr;
        tg_nx    = tg;
        tb_nx    = tb;
        dg_nx    = dg;
        cnt_nx   = run_cnt;
        issue    = 1'b0;
        px       = prev;
        unique case (state)
            S_OP: if (acc) begin
                unique case (1'b1)
                    op_rgb:  state_nx = S_RGB_R;
                    op_rgba: state_nx = S_RGBA_R;
                    op_idx: begin
                        issue = 1'b1;
                        px    = idx_vld[istream[5:0]] ? idx_mem[istream[5:0]] : '0;
                    end
                    op_diff: begin
                        issue = 1'b1;
                        px    = {df_r, df_g, df_b, pa};
                    end
                    op_luma: begin
                        dg_nx    = {2'd0, istream[5:0]} - 8'd32;
                        state_nx = S_LUMA2;
                    end
                    op_run: begin
                        issue  = 1'b1;
                        cnt_nx = istream[5:0];
                        if (istream[5:0] != 6'd0) state_nx = S_RUN;
                    end
                endcase
            end
            S_RGB_R: if (acc) begin tr_nx = istream; state_nx = S_RGB_G; end
            S_RGB_G: if (acc) begin tg_nx = istream; state_nx = S_RGB_B; end
            S_RGB_B: if (acc) begin
                issue    = 1'b1;
                px       = {tr, tg, istream, pa};
                state_nx = S_OP;
            end
            S_RGBA_R: if (acc) begin tr_nx = istream; state_nx = S_RGBA_G; end
            S_RGBA_G: if (acc) begin tg_nx = istream; state_nx = S_RGBA_B; end
            S_RGBA_B: if (acc) begin tb_nx = istream; state_nx = S_RGBA_A; end
            S_RGBA_A: if (acc) begin
                issue    = 1'b1;
                px       = {tr, tg, tb, istream};
                state_nx = S_OP;
            end
            S_LUMA2: if (acc) begin
                issue    = 1'b1;
                px       = {lu_r, lu_g, lu_b, pa};
                state_nx = S_OP;
            end
            S_RUN: if (out_free) begin
                issue  = 1'b1;
                cnt_nx = run_cnt - 6'd1;
                if (run_cnt == 6'd1) state_nx = S_OP;
            end
            default: state_nx = S_OP;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)           state <= S_OP;
        else if (frame_start) state <= S_OP;
        else                  state <= state_nx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev    <= 32'h0000_00FF;
            idx_vld <= '0;
            run_cnt <= '0;
            pix_q   <= '0;
            vld_q   <= 1'b0;
            tr      <= '0;
            tg      <= '0;
            tb      <= '0;
            dg      <= '0;
        end else if (frame_start) begin
            prev    <= 32'h0000_00FF;
            idx_vld <= '0;
            run_cnt <= '0;
            vld_q   <= 1'b0;
        end else begin
            run_cnt <= cnt_nx;
            tr      <= tr_nx;
            tg      <= tg_nx;
            tb      <= tb_nx;
            dg      <= dg_nx;
            if (issue) begin
                pix_q         <= px;
                vld_q         <= 1'b1;
                prev          <= px;
                idx_vld[slot] <= 1'b1;
            end else if (pixel_ready) begin
                vld_q <= 1'b0;
            end
        end
    end

    // Entries are qualified by idx_vld, so the storage itself needs no reset
    always_ff @(posedge clk) begin
        if (issue && !frame_start) idx_mem[slot] <= px;
    end

    if (COMPONENTS == 3) begin : g_rgb
        assign pixel = pix_q[31:8];
    end else begin : g_rgba
        assign pixel = pix_q;
    end
endmodule

// File: tb/tb_qoi_decoder.sv
// tb_qoi_decoder: directed and randomized checks of qoi_decoder.
// Expected pixels come from a chunk-level interpreter of the byte stream.
module tb_qoi_decoder;
    typedef logic [7:0] bq_t[$];

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        frame_start = 1'b0;
    logic [7:0]  istream = 8'h00;
    logic        istream_valid = 1'b0;
    logic        istream_ready;
    logic [31:0] pixel;
    logic        pixel_valid;
    logic        pixel_ready = 1'b0;

    int n_chk = 0;
    int n_err = 0;

    bq_t         bq;
    logic [31:0] eq[$];
    logic [31:0] mp;
    logic [31:0] mi[64];
    bit   [63:0] mv;

    qoi_decoder #(.COMPONENTS(4)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .frame_start   (frame_start),
        .istream       (istream),
        .istream_valid (istream_valid),
        .istream_ready (istream_ready),
        .pixel         (pixel),
        .pixel_valid   (pixel_valid),
        .pixel_ready   (pixel_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] pk(int r, int g, int b, int a);
        return {8'(r), 8'(g), 8'(b), 8'(a)};
    endfunction

    task automatic model_reset();
        mp = 32'h0000_00FF;
        mv = '0;
    endtask

    task automatic emit(input logic [31:0] p);
        int h;
        h = (3 * int'(p[31:24]) + 5 * int'(p[23:16])
           + 7 * int'(p[15:8]) + 11 * int'(p[7:0])) % 64;
        eq.push_back(p);
        mp    = p;
        mi[h] = p;
        mv[h] = 1'b1;
    endtask

    // Walks whole chunks of the stream, appending the pixels they produce
    task automatic model(input bq_t q);
        int i = 0;
        int r, g, b, a, dg;
        logic [7:0] op, nb;
        while (i < q.size()) begin
            op = q[i];
            r = int'(mp[31:24]);
            g = int'(mp[23:16]);
            b = int'(mp[15:8]);
            a = int'(mp[7:0]);
            if (op == 8'hFE) begin
                emit({q[i+1], q[i+2], q[i+3], mp[7:0]});
                i += 4;
            end else if (op == 8'hFF) begin
                emit({q[i+1], q[i+2], q[i+3], q[i+4]});
                i += 5;
            end else begin
                case (op[7:6])
                    2'd0: emit(mv[op[5:0]] ? mi[op[5:0]] : 32'h0);
                    2'd1: emit(pk(r + int'(op[5:4]) - 2, g + int'(op[3:2]) - 2,
                                  b + int'(op[1:0]) - 2, a));
                    2'd2: begin
                        dg = int'(op[5:0]) - 32;
                        nb = q[i+1];
                        emit(pk(r + dg + int'(nb[7:4]) - 8, g + dg,
                                b + dg + int'(nb[3:0]) - 8, a));
                        i += 1;
                    end
                    default:
                        for (int j = 0; j <= int'(op[5:0]); j++) emit(mp);
                endcase
                i += 1;
            end
        end
    endtask

    task automatic gen(input int n, output bq_t q);
        logic [7:0] v;
        q = {};
        for (int k = 0; k < n; k++) begin
            v = 8'($urandom);
            case ($urandom_range(5))
                0: begin
                    q.push_back(8'hFE);
                    repeat (3) q.push_back(8'($urandom));
                end
                1: begin
                    q.push_back(8'hFF);
                    repeat (3) q.push_back(8'($urandom));
                    q.push_back($urandom_range(1) ? 8'hFF : 8'($urandom));
                end
                2: q.push_back({2'b00, v[5:0]});
                3: q.push_back({2'b01, v[5:0]});
                4: begin
                    q.push_back({2'b10, v[5:0]});
                    q.push_back(8'($urandom));
                end
                default: q.push_back(8'hC0 | 8'($urandom_range(
                             $urandom_range(3) == 0 ? 61 : 7)));
            endcase
        end
    endtask

    // Streams bq with random valid/ready duty and compares every accepted pixel
    task automatic run(input int vp, input int rp, input int budget);
        int n = 0;
        bit hold = 1'b0;
        logic [31:0] hp = '0;
        while ((bq.size() != 0 || eq.size() != 0) && n < budget) begin
            @(negedge clk);
            if (hold) begin
                check("hold_valid", 32'(pixel_valid), 1);
                check("hold_pixel", pixel, hp);
            end
            istream_valid = bq.size() != 0 && $urandom_range(99) < vp;
            istream       = bq.size() != 0 ? bq[0] : 8'h00;
            pixel_ready   = $urandom_range(99) < rp;
            #1;
            if (pixel_valid && !pixel_ready)
                check("stall_ready", 32'(istream_ready), 0);
            if (istream_valid && istream_ready) void'(bq.pop_front());
            if (pixel_valid && pixel_ready) begin
                check("pixel_due", 32'(eq.size() != 0), 1);
                if (eq.size() != 0) check("pixel", pixel, eq.pop_front());
            end
            hold = pixel_valid && !pixel_ready;
            hp   = pixel;
            n++;
        end
        check("stream_done", 32'(bq.size() + eq.size()), 0);
        bq.delete();
        eq.delete();
        @(negedge clk);
        istream_valid = 1'b0;
        pixel_ready   = 1'b1;
    endtask

    // Back-to-back bytes into an empty output; pixel must follow next cycle
    task automatic lat_chunk(input int n, input logic [7:0] b0, input logic [7:0] b1,
                             input logic [7:0] b2, input logic [7:0] b3);
        bq_t q;
        logic [7:0] bs[4];
        bs = '{b0, b1, b2, b3};
        for (int i = 0; i < n; i++) q.push_back(bs[i]);
        model(q);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            istream       = q[i];
            istream_valid = 1'b1;
            pixel_ready   = 1'b1;
            #1;
            check("byte_ready", 32'(istream_ready), 1);
        end
        @(negedge clk);
        istream_valid = 1'b0;
        check("lat_valid", 32'(pixel_valid), 1);
        check("lat_count", 32'(eq.size()), 1);
        if (eq.size() != 0) check("lat_pixel", pixel, eq.pop_front());
    endtask

    task automatic frame_pulse();
        @(negedge clk);
        frame_start = 1'b1;
        @(negedge clk);
        frame_start   = 1'b0;
        istream_valid = 1'b0;
        check("frame_drop", 32'(pixel_valid), 0);
        model_reset();
        eq.delete();
    endtask

    initial begin
        bq_t q;
        model_reset();
        pixel_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_valid", 32'(pixel_valid), 0);
        check("rst_pixel", pixel, 0);
        check("rst_ready", 32'(istream_ready), 0);
        rst_n = 1'b1;
        #1;
        check("post_rst_ready", 32'(istream_ready), 1);

        lat_chunk(4, 8'hFE, 8'h10, 8'h20, 8'h30);
        lat_chunk(1, 8'h7F, 8'h00, 8'h00, 8'h00);
        lat_chunk(1, 8'h00, 8'h00, 8'h00, 8'h00);

        // Run of four: one pixel per cycle, input stalled for the middle three
        q = {8'hC3};
        model(q);
        @(negedge clk);
        istream       = 8'hC3;
        istream_valid = 1'b1;
        pixel_ready   = 1'b1;
        #1;
        check("run_accept", 32'(istream_ready), 1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            istream_valid = 1'b0;
            check("run_valid", 32'(pixel_valid), 1);
            check("run_ready", 32'(istream_ready), 32'(k == 3));
            if (eq.size() != 0) check("run_pixel", pixel, eq.pop_front());
        end
        check("run_count", 32'(eq.size()), 0);

        frame_pulse();
        lat_chunk(2, 8'hA0, 8'h88, 8'h00, 8'h00);
        lat_chunk(2, 8'hBF, 8'h08, 8'h00, 8'h00);

        // Backpressure: held pixel blocks the following RGBA chunk
        q = {8'h7F, 8'hFF, 8'h12, 8'h34, 8'h56, 8'h78};
        model(q);
        @(negedge clk);
        istream       = 8'h7F;
        istream_valid = 1'b1;
        pixel_ready   = 1'b0;
        #1;
        check("bp_first", 32'(istream_ready), 1);
        repeat (5) begin
            @(negedge clk);
            istream       = 8'hFF;
            istream_valid = 1'b1;
            pixel_ready   = 1'b0;
            #1;
            check("bp_ready", 32'(istream_ready), 0);
            check("bp_valid", 32'(pixel_valid), 1);
            check("bp_pixel", pixel, eq[0]);
        end
        bq = {8'hFF, 8'h12, 8'h34, 8'h56, 8'h78};
        run(100, 100, 100);

        // frame_start after the G byte wins over the B byte offered with it
        q = {8'hFF, 8'h44, 8'h55, 8'h66};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            istream       = q[i];
            istream_valid = 1'b1;
            pixel_ready   = 1'b1;
            frame_start   = i == 3;
        end
        @(negedge clk);
        frame_start   = 1'b0;
        istream_valid = 1'b0;
        check("abort_valid", 32'(pixel_valid), 0);
        model_reset();
        eq.delete();
        lat_chunk(1, 8'h6A, 8'h00, 8'h00, 8'h00);
        lat_chunk(1, 8'h00, 8'h00, 8'h00, 8'h00);

        frame_pulse();
        for (int r = 0; r < 8; r++) begin
            gen(40, q);
            model(q);
            bq = q;
            run(r == 0 ? 100 : $urandom_range(100, 30),
                r == 0 ? 100 : $urandom_range(100, 30), 20000);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end
endmodule
